dtree_feature_feeder: RTL and testbench
=======================================

// Module: dtree_feature_feeder
// PURPOSE
//  Upstream transmitter for the dtree sample interface.
//  - Collects FEATURES ADC samples per spike window into a buffer.
//  - Streams them to dtree over ready/valid, re-sending the full set each time dtree requests another tree level.
//  - Captures the final level/path result, then frees the buffer for the next window.
//  - Sits between the spike-window front end and dtree; replaces the behavioural feeder used in simulation.
// PARAMETERS
//  FEATURES    3   samples per classification window
//  IN_WIDTH    10  sample width, bits
//  MAX_LEVELS  3   max full-set transmissions per window before abort
// PORTS
//  clk           in   1         clock, rising edge
//  reset         in   1         asynchronous, active-high
//  adc_valid     in   1         upstream sample valid
//  adc_sample    in   IN_WIDTH  upstream sample
//  adc_ready     out  1         feeder can accept an upstream sample
//  dt_ready      in   1         dtree ready for a sample beat
//  dt_valid      out  1         sample beat valid to dtree
//  dt_sample     out  IN_WIDTH  sample to dtree
//  dt_level      in   2         dtree result level
//  dt_path       in   2         dtree result path
//  dt_out_valid  in   1         dtree result strobe
//  cls_valid     out  1         one-cycle result strobe
//  cls_level     out  2         registered level
//  cls_path      out  2         registered path
//  cls_abort     out  1         one-cycle pulse: MAX_LEVELS exceeded
// BEHAVIOUR
//  Reset: async.
//  - All outputs 0. State LOAD, wr_idx=0, rd_idx=0, pass_cnt=0.
//  - Buffer contents are don't-care after reset.
//  LOAD:
//  - adc_ready=1. Each adc_valid&&adc_ready writes buf[wr_idx] and increments wr_idx.
//  - On the FEATURES-th write: adc_ready drops the next cycle, wr_idx clears, state goes to SEND.
//  SEND:
//  - dt_valid=1 and dt_sample=buf[rd_idx]; both are registered outputs.
//  - A beat completes when dt_valid&&dt_ready. rd_idx then increments and the next sample appears the next cycle.
//  - dt_ready low: dt_valid and dt_sample hold stable. dt_valid is never withdrawn without a completed beat.
//  - After beat FEATURES-1 completes: dt_valid=0 next cycle, rd_idx=0, pass_cnt++, state goes to WAIT.
//  WAIT:
//  - dt_out_valid: register level/path, cls_valid=1 for exactly one cycle, pass_cnt=0, state goes to LOAD.
//  - Else dt_ready=1: replay request.
//    - pass_cnt<MAX_LEVELS: state goes to SEND, resending from buf[0].
//    - pass_cnt==MAX_LEVELS: cls_abort pulses for one cycle, pass_cnt=0, state goes to LOAD.
//  - dt_out_valid and dt_ready in the same cycle: dt_out_valid wins (result, no replay).
//  dt_out_valid outside WAIT: ignored. No cls_valid is generated and no state change occurs.
//  Upstream backpressure: no sample is ever dropped. adc_ready=0 in SEND and WAIT, so upstream must stall.
//  Throughput: one beat per cycle when dt_ready is held high.
//  Minimum latency:
//  - Last upstream write to first dt_valid: 1 cycle.
//  - dt_out_valid to cls_valid: 1 cycle.
//  Reset mid-transfer aborts the window immediately; no partial result is emitted.
// CONFIGURATION
//  DTREE_FEEDER_STATS_EN defined adds two outputs:
//  - cls_count [15:0]: wraps at 16'hFFFF to 0; +1 per cls_valid.
//  - replay_max [1:0]: peak pass_cnt seen, saturating.
//  - Both reset to 0.
//  DTREE_FEEDER_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  dtree_pkg holds:
//  - State encodings ST_LOAD=0, ST_SEND=1, ST_WAIT=2.
//  - Result width constants LEVEL_W=2, PATH_W=2.
//  Sub-module dtree_feature_buf:
//  - FEATURES x IN_WIDTH register bank.
//  - One write port (we, wr_idx) and one registered read port (rd_idx).
//  Top level holds the FSM, index/pass counters and result registers.
// TESTING
//  1. Load 5,17,1023 with dt_ready=1; dtree returns out_valid after pass 1.
//     -> dt_sample sequence 5,17,1023; cls_valid one cycle with the driven level/path.
//  2. dtree requests 3 passes.
//     -> 9 beats total, each pass 5,17,1023 in order; result after pass 3; cls_abort=0.
//  3. dtree requests a 4th pass.
//     -> cls_abort pulse; no cls_valid; adc_ready=1 next cycle.
//  4. Toggle dt_ready randomly 50% during SEND.
//     -> dt_sample stable while dt_valid&&!dt_ready; no beat lost or duplicated.
//  5. Assert dt_out_valid and dt_ready together in WAIT.
//     -> result captured; no replay beat issued.
//  6. Reset asserted mid-SEND (beat 2).
//     -> all outputs 0 asynchronously; next window starts clean at buf[0].

Source files
------------

// File: rtl/dtree_pkg.sv
// rtl/dtree_pkg.sv - shared state encoding and result widths for the dtree feature feeder
package dtree_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam int LEVEL_W = 2;
  localparam int PATH_W  = 2;

endpackage

// File: rtl/dtree_feature_buf.sv
// rtl/dtree_feature_buf.sv - FEATURES x IN_WIDTH sample bank, one write port, one registered read port
module dtree_feature_buf #(
  parameter int FEATURES = 3,
  parameter int IN_WIDTH = 10,
  parameter int IW       = (FEATURES > 1) ? $clog2(FEATURES) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                we_i,
  input  logic [IW-1:0]       wr_idx_i,
  input  logic [IN_WIDTH-1:0] wr_data_i,
  input  logic                rd_en_i,
  input  logic [IW-1:0]       rd_idx_i,
  output logic [IN_WIDTH-1:0] rd_data_o
);

  logic [IN_WIDTH-1:0] mem_q [FEATURES];
  logic [IN_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Write-through bypass so a read of the slot being written sees the new sample.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= (we_i && (wr_idx_i == rd_idx_i)) ? wr_data_i : mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dtree_feature_feeder.sv
// rtl/dtree_feature_feeder.sv - buffers one spike window and replays it to dtree per level request
// Optional stats outputs (cls_count, replay_max) under DTREE_FEEDER_STATS_EN.
module dtree_feature_feeder
  import dtree_pkg::*;
#(
  parameter int FEATURES   = 3,
  parameter int IN_WIDTH   = 10,
  parameter int MAX_LEVELS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                adc_valid,
  input  logic [IN_WIDTH-1:0] adc_sample,
  output logic                adc_ready,
  input  logic                dt_ready,
  output logic                dt_valid,
  output logic [IN_WIDTH-1:0] dt_sample,
  input  logic [LEVEL_W-1:0]  dt_level,
  input  logic [PATH_W-1:0]   dt_path,
  input  logic                dt_out_valid,
  output logic                cls_valid,
  output logic [LEVEL_W-1:0]  cls_level,
  output logic [PATH_W-1:0]   cls_path,
`ifdef DTREE_FEEDER_STATS_EN
  output logic [15:0]         cls_count,
  output logic [1:0]          replay_max,
`endif
  output logic                cls_abort
);

  localparam int IW = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int PW = $clog2(MAX_LEVELS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FEATURES - 1);
  localparam logic [PW-1:0] MAX_PASS = PW'(MAX_LEVELS);

  state_e               state_q, state_d;
  logic [IW-1:0]        wr_idx_q, wr_idx_d;
  logic [IW-1:0]        rd_idx_q, rd_idx_d;
  logic [PW-1:0]        pass_q, pass_d;
  logic                 adc_ready_q, adc_ready_d;
  logic                 dt_valid_q, dt_valid_d;
  logic                 cls_valid_q, cls_valid_d;
  logic                 cls_abort_q, cls_abort_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [PATH_W-1:0]    path_q, path_d;
  logic                 buf_we, buf_re;
  logic [IW-1:0]        buf_raddr;
  logic                 in_fire, beat;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    pass_d      = pass_q;
    dt_valid_d  = dt_valid_q;
    cls_valid_d = 1'b0;
    cls_abort_d = 1'b0;
    level_d     = level_q;
    path_d      = path_q;
    buf_we      = 1'b0;
    buf_re      = 1'b0;
    buf_raddr   = '0;
    in_fire     = adc_valid && adc_ready_q;
    beat        = dt_valid_q && dt_ready;

    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          buf_we = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d   = '0;
            state_d    = ST_SEND;
            dt_valid_d = 1'b1;
            buf_re     = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (beat) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d   = '0;
            dt_valid_d = 1'b0;
            pass_d     = pass_q + 1'b1;
            state_d    = ST_WAIT;
          end else begin
            rd_idx_d  = rd_idx_q + 1'b1;
            buf_re    = 1'b1;
            buf_raddr = rd_idx_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A result in the same cycle as a replay request takes priority.
        if (dt_out_valid) begin
          level_d     = dt_level;
          path_d      = dt_path;
          cls_valid_d = 1'b1;
          pass_d      = '0;
          state_d     = ST_LOAD;
        end else if (dt_ready) begin
          if (pass_q < MAX_PASS) begin
            state_d    = ST_SEND;
            dt_valid_d = 1'b1;
            buf_re     = 1'b1;
          end else begin
            cls_abort_d = 1'b1;
            pass_d      = '0;
            state_d     = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    adc_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      pass_q      <= '0;
      adc_ready_q <= 1'b0;
      dt_valid_q  <= 1'b0;
      cls_valid_q <= 1'b0;
      cls_abort_q <= 1'b0;
      level_q     <= '0;
      path_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      pass_q      <= pass_d;
      adc_ready_q <= adc_ready_d;
      dt_valid_q  <= dt_valid_d;
      cls_valid_q <= cls_valid_d;
      cls_abort_q <= cls_abort_d;
      level_q     <= level_d;
      path_q      <= path_d;
    end
  end

  dtree_feature_buf #(
    .FEATURES (FEATURES),
    .IN_WIDTH (IN_WIDTH),
    .IW       (IW)
  ) u_buf (
    .clk_i     (clk),
    .reset_i   (reset),
    .we_i      (buf_we),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (adc_sample),
    .rd_en_i   (buf_re),
    .rd_idx_i  (buf_raddr),
    .rd_data_o (dt_sample)
  );

`ifdef DTREE_FEEDER_STATS_EN
  logic [15:0] cls_count_q;
  logic [1:0]  replay_max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_count_q  <= '0;
      replay_max_q <= '0;
    end else begin
      if (cls_valid_q) begin
        cls_count_q <= cls_count_q + 16'd1;
      end
      if (32'(pass_q) > 32'(replay_max_q)) begin
        replay_max_q <= (32'(pass_q) > 3) ? 2'd3 : 2'(pass_q);
      end
    end
  end

  assign cls_count  = cls_count_q;
  assign replay_max = replay_max_q;
`endif

  assign adc_ready = adc_ready_q;
  assign dt_valid  = dt_valid_q;
  assign cls_valid = cls_valid_q;
  assign cls_abort = cls_abort_q;
  assign cls_level = level_q;
  assign cls_path  = path_q;

endmodule

// File: tb/tb_dtree_feature_feeder.sv
// tb/tb_dtree_feature_feeder.sv - randomized window/replay bench for dtree_feature_feeder
module tb_dtree_feature_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       adc_valid = 1'b0;
  logic [9:0] adc_sample = '0;
  logic       adc_ready;
  logic       dt_ready = 1'b0;
  logic       dt_valid;
  logic [9:0] dt_sample;
  logic [1:0] dt_level = '0;
  logic [1:0] dt_path = '0;
  logic       dt_out_valid = 1'b0;
  logic       cls_valid;
  logic [1:0] cls_level;
  logic [1:0] cls_path;
  logic       cls_abort;
`ifdef DTREE_FEEDER_STATS_EN
  logic [15:0] cls_count;
  logic [1:0]  replay_max;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] win [3];
  int model_cls = 0;
  int model_peak = 0;

  always #5 clk = ~clk;

  dtree_feature_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .adc_valid    (adc_valid),
    .adc_sample   (adc_sample),
    .adc_ready    (adc_ready),
    .dt_ready     (dt_ready),
    .dt_valid     (dt_valid),
    .dt_sample    (dt_sample),
    .dt_level     (dt_level),
    .dt_path      (dt_path),
    .dt_out_valid (dt_out_valid),
    .cls_valid    (cls_valid),
    .cls_level    (cls_level),
    .cls_path     (cls_path),
`ifdef DTREE_FEEDER_STATS_EN
    .cls_count    (cls_count),
    .replay_max   (replay_max),
`endif
    .cls_abort    (cls_abort)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_dt_valid"}, dt_valid, 0);
    check_eq({tag, "_dt_sample"}, dt_sample, 0);
    check_eq({tag, "_adc_ready"}, adc_ready, 0);
    check_eq({tag, "_cls_valid"}, cls_valid, 0);
    check_eq({tag, "_cls_abort"}, cls_abort, 0);
    check_eq({tag, "_cls_lp"}, {cls_level, cls_path}, 0);
  endtask

  task automatic load_window();
    int i = 0;
    int t = 0;
    while (i < 3 && t < 60) begin
      @(negedge clk);
      t++;
      dt_ready = 1'b0;
      dt_out_valid = 1'b0;
      adc_valid = ($urandom_range(0, 3) != 0);
      adc_sample = adc_valid ? win[i] : 10'($urandom);
      if (adc_valid && adc_ready) i++;
    end
    check_eq("load_done", i, 3);
    @(negedge clk);
    adc_valid = 1'b0;
    check_eq("load_lat_valid", dt_valid, 1);
    check_eq("load_lat_sample", dt_sample, win[0]);
    check_eq("load_ready_drop", adc_ready, 0);
  endtask

  task automatic run_window(input int passes, input bit rnd_rdy, input bit both_rdy, input bit noise);
    logic [9:0] obs [$];
    logic [9:0] hold_s = '0;
    logic [1:0] lv, pt;
    int beats = 0;
    int req = 1;
    int cyc = 0;
    int exp_passes;
    bit done = 0, saw_res = 0, saw_abort = 0, hold = 0, res_drv = 0, ab_drv = 0;
    lv = 2'($urandom);
    pt = 2'($urandom);
    exp_passes = (passes > 3) ? 3 : passes;
    load_window();
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      dt_ready = 1'b0;
      dt_out_valid = 1'b0;
      if (hold) begin
        check_eq("hold_valid", dt_valid, 1);
        check_eq("hold_sample", dt_sample, hold_s);
      end
      if (res_drv) check_eq("result_latency", cls_valid, 1);
      if (ab_drv) check_eq("abort_latency", cls_abort, 1);
      res_drv = 0;
      ab_drv = 0;
      if (cls_valid || cls_abort) begin
        saw_res = cls_valid;
        saw_abort = cls_abort;
        if (cls_valid) begin
          check_eq("cls_level", cls_level, lv);
          check_eq("cls_path", cls_path, pt);
        end else begin
          check_eq("abort_adc_ready", adc_ready, 1);
        end
        check_eq("end_dt_valid", dt_valid, 0);
        done = 1;
      end else if (beats == 3 * req && !dt_valid) begin
        if (req < passes) begin
          dt_ready = 1'b1;
          req++;
          if (req > 3) ab_drv = 1;
        end else begin
          dt_out_valid = 1'b1;
          dt_level = lv;
          dt_path = pt;
          dt_ready = both_rdy;
          res_drv = 1;
        end
      end else begin
        dt_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (noise) begin
          dt_out_valid = ($urandom_range(0, 3) == 0);
          dt_level = 2'($urandom);
          dt_path = 2'($urandom);
        end
      end
      hold = dt_valid && !dt_ready;
      hold_s = dt_sample;
      if (dt_valid && dt_ready) begin
        obs.push_back(dt_sample);
        beats++;
      end
    end
    check_eq("window_done", done, 1);
    check_eq("beat_count", obs.size(), 3 * exp_passes);
    for (int k = 0; k < obs.size() && k < 3 * exp_passes; k++) begin
      check_eq("beat_data", obs[k], win[k % 3]);
    end
    check_eq("cls_valid_seen", saw_res, (passes <= 3));
    check_eq("cls_abort_seen", saw_abort, (passes > 3));
    if (saw_res) model_cls++;
    if (exp_passes > model_peak) model_peak = exp_passes;
    @(negedge clk);
    check_eq("pulse_end_valid", cls_valid, 0);
    check_eq("pulse_end_abort", cls_abort, 0);
    check_eq("no_replay_beat", dt_valid, 0);
    check_eq("back_to_load", adc_ready, 1);
`ifdef DTREE_FEEDER_STATS_EN
    check_eq("stat_cls_count", cls_count, model_cls);
    check_eq("stat_replay_max", replay_max, model_peak);
`endif
  endtask

  task automatic rand_win();
    for (int k = 0; k < 3; k++) win[k] = 10'($urandom_range(0, 1023));
  endtask

  initial begin
    #23;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_reset_ready", adc_ready, 1);

    win[0] = 10'd5; win[1] = 10'd17; win[2] = 10'd1023;
    run_window(1, 0, 0, 0);
    run_window(3, 0, 0, 0);
    run_window(4, 0, 0, 0);

    rand_win();
    run_window(2, 1, 0, 1);
    rand_win();
    run_window(2, 0, 1, 0);

    rand_win();
    load_window();
    @(negedge clk);
    dt_ready = 1'b1;
    @(negedge clk);
    dt_ready = 1'b0;
    check_eq("mid_send_sample", dt_sample, win[1]);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    model_cls = 0;
    model_peak = 0;
    @(negedge clk);
    reset = 1'b0;
    rand_win();
    run_window(1, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      rand_win();
      run_window($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
